// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the code-memory port, the redirect request and the
// decode-side valid/ready stream of the instruction fetch controller.
//   mem_addr/mem_inst         - synchronous code memory (1-cycle read latency)
//   redirect_valid/redirect_pc - branch/jump restart request
//   out_valid/out_ready/out_inst/out_pc - fetched word stream to decode
//   fault                     - sticky out-of-range fetch flag
// Modports: master = fetch controller, slave = memory/decode environment.
interface fetch_ctrl_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        fault;

    modport master (
        output mem_addr, out_valid, out_inst, out_pc, fault,
        input  mem_inst, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  mem_addr, out_valid, out_inst, out_pc, fault,
        output mem_inst, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller. Owns the fetch PC, drives the
// code memory address every cycle, tracks the single in-flight read and
// buffers returned words in a 2-entry skid FIFO toward decode.
// Ports:
//   clk   - clock, all state on posedge
//   reset - synchronous, active-high
//   bus   - fetch_ctrl_if.master (memory, redirect, decode stream, fault)
// Parameters:
//   SIZE     - code memory size in bytes (power of two, multiple of 4)
//   RESET_PC - fetch PC after reset (word-aligned)
// Build option: define FETCH_BOUNDS_CHECK_EN to stop fetching and raise the
// sticky fault flag when the fetch PC reaches SIZE; otherwise fault is 0.
module fetch_ctrl #(
    parameter int unsigned SIZE     = 1024,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    if ((SIZE < 4) || ((SIZE & (SIZE - 1)) != 0)) begin : g_bad_size
        $error("fetch_ctrl: SIZE must be a power of two and at least 4");
    end

    logic [31:0] r_fetch_pc, w_fetch_pc_d;
    logic        r_infl_v, w_infl_v_d;
    logic [31:0] r_infl_pc, w_infl_pc_d;
    logic [1:0]  r_occ, w_occ_d;
    logic [31:0] r_fifo_pc   [2];
    logic [31:0] r_fifo_inst [2];
    logic [31:0] w_fifo_pc_d   [2];
    logic [31:0] w_fifo_inst_d [2];

    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_cnt;
    logic        w_attempt;
    logic        w_issue;
    logic        w_fault;
    logic [1:0]  w_slot;

    assign w_pop  = (r_occ != 2'd0) && bus.out_ready;
    assign w_push = r_infl_v && !bus.redirect_valid;

    // Entries that will be buffered or in flight after this cycle's pop;
    // a new read is only started when a slot is guaranteed for its return.
    assign w_cnt     = {1'b0, r_occ} + {2'b00, r_infl_v} - {2'b00, w_pop};
    assign w_attempt = !bus.redirect_valid && !w_fault && (w_cnt < 3'd2);

`ifdef FETCH_BOUNDS_CHECK_EN
    logic r_fault;
    logic w_oob;

    assign w_oob   = r_fetch_pc >= 32'(SIZE);
    assign w_issue = w_attempt && !w_oob;
    assign w_fault = r_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_fault <= 1'b0;
        end else if (w_attempt && w_oob) begin
            r_fault <= 1'b1;
        end
    end
`else
    assign w_issue = w_attempt;
    assign w_fault = 1'b0;
`endif

    // Slot the returning word lands in, after the head has shifted out.
    assign w_slot = r_occ - {1'b0, w_pop};

    always_comb begin
        w_fetch_pc_d  = r_fetch_pc;
        w_infl_v_d    = 1'b0;
        w_infl_pc_d   = r_infl_pc;
        w_occ_d       = r_occ;
        w_fifo_pc_d   = r_fifo_pc;
        w_fifo_inst_d = r_fifo_inst;

        if (bus.redirect_valid) begin
            // Squash buffered and in-flight words; a pop this cycle still counts.
            w_occ_d      = 2'd0;
            w_fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
        end else begin
            if (w_pop) begin
                w_fifo_pc_d[0]   = r_fifo_pc[1];
                w_fifo_inst_d[0] = r_fifo_inst[1];
            end
            if (w_push) begin
                w_fifo_pc_d[w_slot[0]]   = r_infl_pc;
                w_fifo_inst_d[w_slot[0]] = bus.mem_inst;
            end
            w_occ_d = r_occ + {1'b0, w_push} - {1'b0, w_pop};
            if (w_issue) begin
                w_infl_v_d   = 1'b1;
                w_infl_pc_d  = r_fetch_pc;
                w_fetch_pc_d = r_fetch_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_infl_v   <= 1'b0;
            r_occ      <= 2'd0;
        end else begin
            r_fetch_pc <= w_fetch_pc_d;
            r_infl_v   <= w_infl_v_d;
            r_occ      <= w_occ_d;
        end
    end

    // Data registers need no reset; they are only observed when occupied.
    always_ff @(posedge clk) begin
        r_infl_pc   <= w_infl_pc_d;
        r_fifo_pc   <= w_fifo_pc_d;
        r_fifo_inst <= w_fifo_inst_d;
    end

    assign bus.mem_addr  = r_fetch_pc;
    assign bus.out_valid = (r_occ != 2'd0);
    assign bus.out_inst  = r_fifo_inst[0];
    assign bus.out_pc    = r_fifo_pc[0];
    assign bus.fault     = w_fault;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && (r_occ == 2'd2) && !w_pop))
        else $error("fetch_ctrl: skid FIFO overflow");

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed, table-driven bench for fetch_ctrl. Each vector
// gives one cycle of inputs plus the outputs expected during that cycle.
// The code memory model returns 32'h1000_0000 + word index one cycle later.
module tb_fetch_ctrl;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic BC = 1'b1;
`else
    localparam logic BC = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .SIZE     (1024),
        .RESET_PC (32'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.mem_inst <= 32'h1000_0000 + (bus.mem_addr >> 2);

    typedef struct {
        logic        chk;
        logic        rst;
        logic        rdv;
        logic [31:0] rdpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic        ef;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int step_no = 0;
    vec_t tbl[$];

    function automatic vec_t mk(logic chk, logic rst, logic rdv, logic [31:0] rdpc, logic rdy,
                                logic ev, logic [31:0] epc, logic [31:0] eaddr, logic ef);
        vec_t t;
        t.chk = chk; t.rst = rst; t.rdv = rdv; t.rdpc = rdpc; t.rdy = rdy;
        t.ev = ev; t.epc = epc; t.eaddr = eaddr; t.ef = ef;
        return t;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL step %0d %s: got %h, expected %h", step_no, name, act, exp);
        end
    endtask

    // Outputs are register-only, so checking at the negedge before or after
    // driving this cycle's inputs gives the same result.
    task automatic step(input vec_t t);
        @(negedge clk);
        reset              = t.rst;
        bus.redirect_valid = t.rdv;
        bus.redirect_pc    = t.rdpc;
        bus.out_ready      = t.rdy;
        if (t.chk) begin
            cmp("out_valid", {31'd0, bus.out_valid}, {31'd0, t.ev});
            if (t.ev) begin
                cmp("out_pc", bus.out_pc, t.epc);
                cmp("out_inst", bus.out_inst, 32'h1000_0000 + (t.epc >> 2));
            end
            cmp("mem_addr", bus.mem_addr, t.eaddr);
            cmp("fault", {31'd0, bus.fault}, {31'd0, t.ef});
        end
        step_no++;
    endtask

    // Reset, then cycles 0..3 streaming with out_ready high.
    task automatic prologue();
        step(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        step(mk(1, 1, 0, 0, 1, 0, 0, 0, 0));
        step(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
        step(mk(1, 0, 0, 0, 1, 0, 0, 4, 0));
        step(mk(1, 0, 0, 0, 1, 1, 0, 8, 0));
        step(mk(1, 0, 0, 0, 1, 1, 4, 12, 0));
    endtask

    initial begin
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b1;

        // Stream from reset, stall cycles 4..9, resume with no gap.
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 4, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 8, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 4, 12, 0));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8, 16, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 8, 16, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 12, 20, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 16, 24, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 20, 28, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 24, 32, 0));
        // Redirect to 0x43 in cycle 6; first new word (0x40) in cycle 9.
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 4, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 8, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 4, 12, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 8, 16, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 12, 20, 0));
        tbl.push_back(mk(1, 0, 1, 32'h43, 1, 1, 16, 24, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 32'h40, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 32'h44, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 32'h40, 32'h48, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 32'h44, 32'h4c, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 32'h48, 32'h50, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Redirect together with a pop while the FIFO is full.
        prologue();
        for (int i = 0; i < 3; i++) step(mk(1, 0, 0, 0, 0, 1, 8, 16, 0));
        step(mk(1, 0, 1, 32'h100, 1, 1, 8, 16, 0));
        step(mk(1, 0, 0, 0, 1, 0, 0, 32'h100, 0));
        step(mk(1, 0, 0, 0, 1, 0, 0, 32'h104, 0));
        step(mk(1, 0, 0, 0, 1, 1, 32'h100, 32'h108, 0));
        step(mk(1, 0, 0, 0, 1, 1, 32'h104, 32'h10c, 0));

        // Reset while the FIFO is full discards everything buffered.
        prologue();
        for (int i = 0; i < 3; i++) step(mk(1, 0, 0, 0, 0, 1, 8, 16, 0));
        step(mk(1, 1, 0, 0, 0, 1, 8, 16, 0));
        step(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
        step(mk(1, 0, 0, 0, 1, 0, 0, 4, 0));
        step(mk(1, 0, 0, 0, 1, 1, 0, 8, 0));
        step(mk(1, 0, 0, 0, 1, 1, 4, 12, 0));

        // Fetch running into the end of code memory, then redirect to 0.
        step(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        step(mk(1, 1, 0, 0, 1, 0, 0, 0, 0));
        step(mk(1, 0, 1, 32'h3f2, 1, 0, 0, 0, 0));
        step(mk(1, 0, 0, 0, 1, 0, 0, 1008, 0));
        step(mk(1, 0, 0, 0, 1, 0, 0, 1012, 0));
        step(mk(1, 0, 0, 0, 1, 1, 1008, 1016, 0));
        step(mk(1, 0, 0, 0, 1, 1, 1012, 1020, 0));
        step(mk(1, 0, 0, 0, 1, 1, 1016, 1024, 0));
        step(mk(1, 0, 0, 0, 1, 1, 1020, BC ? 32'd1024 : 32'd1028, BC));
        step(mk(1, 0, 0, 0, 1, !BC, 1024, BC ? 32'd1024 : 32'd1032, BC));
        step(mk(1, 0, 1, 0, 1, !BC, 1028, BC ? 32'd1024 : 32'd1036, BC));
        step(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
        step(mk(1, 0, 0, 0, 1, 0, 0, 4, 0));
        step(mk(1, 0, 0, 0, 1, 1, 0, 8, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch controller for the 32-bit CPU. It owns the fetch PC and drives the address of the synchronous code memory, which has one-cycle read latency and reads every cycle. It tracks the single in-flight read and buffers returned words in a 2-entry skid FIFO. Words go to decode through a valid/ready handshake, and a redirect (branch/jump) squashes everything in flight.

## Interface
- SIZE, 1024: code memory size in bytes; a power of two, multiple of 4.
- RESET_PC, 32'h0: fetch PC after reset; word-aligned.

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- mem_addr  out  32  byte address to code memory; equals fetch_pc register (combinational from register, no logic).
- mem_inst  in  32  word returned by code memory; valid the cycle after an address is sampled.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0).
- out_valid  out  1  out_inst/out_pc hold a fetched word (FIFO non-empty).
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_inst  out  32  FIFO head instruction.
- out_pc  out  32  byte address of out_inst.
- fault  out  1  sticky out-of-range fetch flag (see Configuration).

## Operation
- State: fetch_pc[31:0], infl_v, infl_pc[31:0], FIFO of 2 entries {pc, inst} with occupancy occ (0..2), fault.
- pop = out_valid && out_ready.
- Issue condition: !reset && !redirect_valid && !fault && (occ + infl_v - pop) < 2.
- On issue: infl_v <= 1, infl_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (mod 2^32, wraps to 0).
- No issue: infl_v <= 0, fetch_pc unchanged. The memory still reads mem_addr, and the data is ignored.
- Return: if infl_v && !redirect_valid, push {infl_pc, mem_inst} at the FIFO tail.
- Push and pop in the same cycle are both performed, and occ is unchanged. The issue condition guarantees a push never occurs with occ==2 && !pop. An overflow is a design error, and a simulation assertion must fire on it.
- Redirect (priority over issue/return):
  - FIFO cleared (occ <= 0), infl_v <= 0, fault <= 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - A pop occurring in the same cycle is a valid transfer.
  - The first fetch of the new PC is issued the following cycle.
- Reset: fetch_pc <= RESET_PC, infl_v <= 0, occ <= 0, fault <= 0. Reset mid-operation discards all in-flight and buffered words, and the memory's reset output is never captured.
- Reset values of outputs:
  - mem_addr = RESET_PC.
  - out_valid = 0.
  - out_inst and out_pc = FIFO head contents; these are don't-care while out_valid=0, and the bench must not check them.
  - fault = 0.

## Timing
- Cycle 0 = first cycle with reset low.
  - Cycle 0: issue of RESET_PC.
  - Cycle 1: word returns and is pushed.
  - Cycle 2: out_valid=1 with out_pc=RESET_PC.
- Fetch-to-output latency: 2 cycles.
- Redirect-to-output latency: 3 cycles (redirect in cycle N, first new word has out_valid in cycle N+3).
- Throughput: 1 word/cycle sustained while out_ready=1.
- Stall: with out_ready low, at most 2 words are buffered and issue stops. When out_ready rises, output resumes in the same cycle with no bubble.
- out_valid, out_inst and out_pc are driven from registers only, with no combinational path from out_ready or redirect_valid.

## Configuration
- FETCH_BOUNDS_CHECK_EN defined:
  - An issue attempt with fetch_pc >= SIZE does not issue and sets fault <= 1.
  - While fault=1, no further issues occur.
  - Words already buffered still drain.
  - fault clears only on redirect or reset.
- FETCH_BOUNDS_CHECK_EN undefined:
  - fault tied to 0.
  - Addresses are issued unchecked, and the memory handles the out-of-range index itself.

## Test plan
- Reset release, RESET_PC=0, out_ready=1, memory word i = 32'h1000_0000+i -> out_valid from cycle 2; out_pc 0,4,8,… with inst 10000000,10000001,… one per cycle, no gaps.
- out_ready low cycles 4–9 -> out_valid stays 1, out_pc frozen, occ reaches 2, mem_addr constant. After out_ready rises, sequence continues with no word lost or duplicated.
- redirect_valid at cycle 6 with redirect_pc=32'h43 -> no pre-redirect word appears after cycle 6; out_pc=32'h40 with out_valid in cycle 9, then 44, 48.
- Redirect asserted in the same cycle as a pop, with occ=2 and infl_v=1 -> the popped word is counted once, and the next output has out_pc = redirect target.
- Sequential fetch reaching pc=SIZE (1024) with FETCH_BOUNDS_CHECK_EN -> last word out_pc=1020, fault=1, out_valid falls after drain. A redirect to 0 clears fault and fetch resumes at 0. Without the macro, fault stays 0 and pc=1024 is issued.
- Reset asserted while occ=2 and infl_v=1 -> next cycle out_valid=0, mem_addr=RESET_PC. First output after release is RESET_PC at cycle 2.
